ras_spill_ctrl: RTL and testbench

Spill/fill controller for the return-address stack. It moves the oldest stack entries to a memory spill region when the stack crosses its fill threshold. It brings them back, newest spilled entry first, when the stack drops to its empty threshold. It drives the stack's push_bottom/pop_bottom/din_bottom port and a simple req/ack memory port.

---
 rtl/ras_spill_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ras_spill_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ras_spill_ctrl.sv
// ras_spill_ctrl: moves the oldest return-address stack entries out to a
// memory spill region when the stack runs high, and brings them back
// (newest spilled entry first) when it runs low. One stack entry moves per
// beat: memory request/ack, then a single pop_bottom or push_bottom pulse.
module ras_spill_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] SPILL_BASE  = 32'h0001_0000,
    parameter int unsigned SPILL_DEPTH = 256,
    parameter int unsigned BURST       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         over_thresh,
    input  logic                         under_thresh,
    input  logic                         stack_empty,
    input  logic                         stack_full,
    input  logic [DATA_WIDTH-1:0]        dout_bottom,
    output logic                         push_bottom,
    output logic                         pop_bottom,
    output logic [DATA_WIDTH-1:0]        din_bottom,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    input  logic                         mem_ack,
    output logic [$clog2(SPILL_DEPTH):0] spill_cnt,
    output logic                         busy,
    output logic                         spill_overflow
);

    localparam int unsigned CW = $clog2(SPILL_DEPTH) + 1;
    localparam int unsigned BW = $clog2(BURST + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(SPILL_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] BURST_C  = BW'(BURST);
    localparam logic [BW-1:0] BEAT_ONE = BW'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SPILL_WR  = 3'd1;
    localparam logic [2:0] S_SPILL_POP = 3'd2;
    localparam logic [2:0] S_FILL_RD   = 3'd3;
    localparam logic [2:0] S_FILL_PUSH = 3'd4;

    logic [2:0]            r_state;
    logic [BW-1:0]         r_beat;
    logic [CW-1:0]         r_spill_cnt;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_din_bottom;
    logic                  r_spill_overflow;

    logic [31:0]           w_cnt_ext;
    logic [31:0]           w_wr_addr;
    logic [31:0]           w_rd_addr;
    logic [CW-1:0]         w_cnt_inc;
    logic [CW-1:0]         w_cnt_dec;
    logic [BW-1:0]         w_beat_inc;
    logic                  w_start_spill;
    logic                  w_overflow_hit;
    logic                  w_start_fill;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_spill_done;
    logic                  w_fill_done;

    // Address arithmetic, counter increments and episode start/stop decode
    always_comb begin
        w_cnt_ext      = 32'(r_spill_cnt);
        w_wr_addr      = SPILL_BASE + (w_cnt_ext << 2);
        w_rd_addr      = SPILL_BASE + ((w_cnt_ext - 32'd1) << 2);
        w_cnt_inc      = r_spill_cnt + CNT_ONE;
        w_cnt_dec      = r_spill_cnt - CNT_ONE;
        w_beat_inc     = r_beat + BEAT_ONE;
        w_start_spill  = ena & over_thresh & ~stack_empty & (r_spill_cnt < DEPTH_C);
        w_overflow_hit = ena & over_thresh & (r_spill_cnt == DEPTH_C);
        w_start_fill   = ena & under_thresh & (r_spill_cnt != '0) & ~stack_full;
        w_pop          = (r_state == S_SPILL_POP) & ~stack_empty;
        w_push         = (r_state == S_FILL_PUSH) & ~stack_full;
        // Episode-end tests use the post-beat counter values
        w_spill_done   = (w_beat_inc == BURST_C) | (w_cnt_inc == DEPTH_C) | ~ena;
        w_fill_done    = (w_beat_inc == BURST_C) | (w_cnt_dec == '0) | ~ena;
    end

    // Spill/fill sequencer: state, beat/spill counters and memory port registers.
    // In SPILL_WR/FILL_RD the registered mem_req doubles as the phase flag:
    // low means the request still has to be issued, high means waiting for ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_beat           <= '0;
            r_spill_cnt      <= '0;
            r_mem_req        <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_din_bottom     <= '0;
            r_spill_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_spill) begin
                        r_state <= S_SPILL_WR;
                        r_beat  <= '0;
                    end else if (w_overflow_hit) begin
                        r_spill_overflow <= 1'b1;
                    end else if (w_start_fill) begin
                        r_state <= S_FILL_RD;
                        r_beat  <= '0;
                    end
                end
                S_SPILL_WR: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_wr_addr;
                        r_mem_wdata <= dout_bottom;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_SPILL_POP;
                    end
                end
                S_SPILL_POP: begin
                    if (stack_empty) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_spill_cnt <= w_cnt_inc;
                        r_beat      <= w_beat_inc;
                        r_state     <= w_spill_done ? S_IDLE : S_SPILL_WR;
                    end
                end
                S_FILL_RD: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_rd_addr;
                    end else if (mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_din_bottom <= mem_rdata;
                        r_state      <= S_FILL_PUSH;
                    end
                end
                S_FILL_PUSH: begin
                    if (stack_full) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_spill_cnt <= w_cnt_dec;
                        r_beat      <= w_beat_inc;
                        r_state     <= w_fill_done ? S_IDLE : S_FILL_RD;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping: pulses decode from state and the live stack flags
    always_comb begin
        pop_bottom     = w_pop;
        push_bottom    = w_push;
        din_bottom     = r_din_bottom;
        mem_req        = r_mem_req;
        mem_we         = r_mem_we;
        mem_addr       = r_mem_addr;
        mem_wdata      = r_mem_wdata;
        spill_cnt      = r_spill_cnt;
        busy           = (r_state != S_IDLE);
        spill_overflow = r_spill_overflow;
    end

endmodule

// File: tb/tb_ras_spill_ctrl.sv
// Directed bench for ras_spill_ctrl. Instance A uses the default 256-entry
// spill region; instance B uses a 4-entry region to reach the overflow case.
module tb_ras_spill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena_a, ena_b;
    logic        over_thresh, under_thresh, stack_empty, stack_full;
    logic [31:0] dout_bottom;
    logic        ack_a, ack_b;
    logic [31:0] rdata_a, rdata_b;

    logic        a_push, a_pop, a_mem_req, a_mem_we, a_busy, a_ovf;
    logic [31:0] a_din, a_mem_addr, a_mem_wdata;
    logic [8:0]  a_cnt;
    logic        b_push, b_pop, b_mem_req, b_mem_we, b_busy, b_ovf;
    logic [31:0] b_din, b_mem_addr, b_mem_wdata;
    logic [2:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ras_spill_ctrl u_a (
        .clk(clk), .rst(rst), .ena(ena_a), .over_thresh(over_thresh),
        .under_thresh(under_thresh), .stack_empty(stack_empty), .stack_full(stack_full),
        .dout_bottom(dout_bottom), .push_bottom(a_push), .pop_bottom(a_pop),
        .din_bottom(a_din), .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(rdata_a), .mem_ack(ack_a),
        .spill_cnt(a_cnt), .busy(a_busy), .spill_overflow(a_ovf)
    );

    ras_spill_ctrl #(.SPILL_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .ena(ena_b), .over_thresh(over_thresh),
        .under_thresh(under_thresh), .stack_empty(stack_empty), .stack_full(stack_full),
        .dout_bottom(dout_bottom), .push_bottom(b_push), .pop_bottom(b_pop),
        .din_bottom(b_din), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(rdata_b), .mem_ack(ack_b),
        .spill_cnt(b_cnt), .busy(b_busy), .spill_overflow(b_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_req(input bit sel);
        return sel ? b_mem_req : a_mem_req;
    endfunction
    function automatic logic get_we(input bit sel);
        return sel ? b_mem_we : a_mem_we;
    endfunction
    function automatic logic get_pop(input bit sel);
        return sel ? b_pop : a_pop;
    endfunction
    function automatic logic [31:0] get_addr(input bit sel);
        return sel ? b_mem_addr : a_mem_addr;
    endfunction
    function automatic logic [31:0] get_wdata(input bit sel);
        return sel ? b_mem_wdata : a_mem_wdata;
    endfunction

    task automatic set_ack(input bit sel, input logic v);
        if (sel) ack_b = v;
        else     ack_a = v;
    endtask

    task automatic wait_req(input bit sel);
        int unsigned n = 0;
        while (!get_req(sel) && n < 20) begin
            step();
            n++;
        end
        check("req_seen", get_req(sel), 1);
    endtask

    // One spill beat: request seen, held 'delay' extra cycles, then acked
    task automatic spill_beat(input bit sel, input logic [31:0] ea, input logic [31:0] ed,
                              input int unsigned delay, input logic ep);
        wait_req(sel);
        check("spill_we", get_we(sel), 1);
        check("spill_addr", get_addr(sel), ea);
        check("spill_wdata", get_wdata(sel), ed);
        check("no_pop_in_wr", get_pop(sel), 0);
        for (int unsigned d = 0; d < delay; d++) begin
            step();
            check("hold_req", get_req(sel), 1);
            check("hold_addr", get_addr(sel), ea);
            check("hold_wdata", get_wdata(sel), ed);
            check("no_early_pop", get_pop(sel), 0);
        end
        set_ack(sel, 1'b1);
        step();
        set_ack(sel, 1'b0);
        check("spill_req_drop", get_req(sel), 0);
        check("pop_pulse", get_pop(sel), ep);
    endtask

    task automatic fill_beat(input logic [31:0] ea, input logic [31:0] rd);
        wait_req(1'b0);
        check("fill_we", a_mem_we, 0);
        check("fill_addr", a_mem_addr, ea);
        check("no_push_in_rd", a_push, 0);
        rdata_a = rd;
        ack_a   = 1'b1;
        step();
        ack_a   = 1'b0;
        rdata_a = 32'hDEAD_BEEF;
        check("fill_req_drop", a_mem_req, 0);
        check("push_pulse", a_push, 1);
        check("din_bottom", a_din, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena_a = 1'b0; ena_b = 1'b0;
        over_thresh = 1'b0; under_thresh = 1'b0; stack_empty = 1'b0; stack_full = 1'b0;
        dout_bottom = '0; ack_a = 1'b0; ack_b = 1'b0; rdata_a = '0; rdata_b = '0;

        // 1: reset
        step(); step();
        check("rst_a_req", a_mem_req, 0);
        check("rst_a_we", a_mem_we, 0);
        check("rst_a_addr", a_mem_addr, 0);
        check("rst_a_wdata", a_mem_wdata, 0);
        check("rst_a_din", a_din, 0);
        check("rst_a_pulses", {a_push, a_pop}, 0);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_b_all", {b_mem_req, b_mem_we, b_push, b_pop, b_busy, b_ovf, b_cnt}, 0);
        rst = 1'b0;
        step();

        // 2: spill burst of 8
        ena_a = 1'b1; over_thresh = 1'b1; dout_bottom = 32'h100;
        step();
        over_thresh = 1'b0;
        for (int k = 0; k < 8; k++) begin
            spill_beat(1'b0, 32'h1_0000 + 32'(4 * k), 32'h100 + 32'(4 * k), 1, 1'b1);
            dout_bottom = 32'h100 + 32'(4 * (k + 1));
        end
        step();
        check("spill_cnt_8", a_cnt, 8);
        check("spill_end_idle", a_busy, 0);
        check("spill_end_no_pop", a_pop, 0);

        // 3: fill burst of 8, newest spilled entry first
        under_thresh = 1'b1;
        step();
        under_thresh = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            fill_beat(32'h1_0000 + 32'(4 * k), 32'h100 + 32'(4 * k));
        end
        step();
        check("fill_cnt_0", a_cnt, 0);
        check("fill_end_idle", a_busy, 0);
        check("fill_end_no_push", a_push, 0);
        check("din_holds", a_din, 32'h100);

        // 4: ack delayed 5 cycles, ena dropped so only one beat runs
        over_thresh = 1'b1; dout_bottom = 32'h200;
        step();
        over_thresh = 1'b0; ena_a = 1'b0;
        spill_beat(1'b0, 32'h1_0000, 32'h200, 5, 1'b1);
        step();
        check("ena_low_cnt", a_cnt, 1);
        check("ena_low_idle", a_busy, 0);

        // 6a: stack empties during the beat: no pop, count unchanged
        ena_a = 1'b1; over_thresh = 1'b1; dout_bottom = 32'h300;
        step();
        over_thresh = 1'b0; stack_empty = 1'b1;
        spill_beat(1'b0, 32'h1_0004, 32'h300, 2, 1'b0);
        step();
        check("empty_cnt", a_cnt, 1);
        check("empty_idle", a_busy, 0);
        stack_empty = 1'b0;

        // 6b: reset during FILL_RD
        under_thresh = 1'b1;
        step();
        under_thresh = 1'b0;
        wait_req(1'b0);
        check("rd_before_rst_addr", a_mem_addr, 32'h1_0000);
        check("rd_before_rst_we", a_mem_we, 0);
        rst = 1'b1;
        step();
        check("rst_mid_req", a_mem_req, 0);
        check("rst_mid_cnt", a_cnt, 0);
        check("rst_mid_busy", a_busy, 0);
        rst = 1'b0; ena_a = 1'b0;
        step();

        // 5: 4-entry spill region fills, then sticky overflow
        ena_b = 1'b1; over_thresh = 1'b1; dout_bottom = 32'h400;
        step();
        for (int k = 0; k < 4; k++) begin
            spill_beat(1'b1, 32'h1_0000 + 32'(4 * k), 32'h400 + 32'(4 * k), 0, 1'b1);
            dout_bottom = 32'h400 + 32'(4 * (k + 1));
        end
        step();
        check("b_cnt_full", b_cnt, 4);
        check("b_idle", b_busy, 0);
        check("b_ovf_not_yet", b_ovf, 0);
        step();
        check("b_ovf_set", b_ovf, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("b_no_req", b_mem_req, 0);
            check("b_ovf_held", b_ovf, 1);
        end
        over_thresh = 1'b0; ena_b = 1'b0;
        step();
        check("b_ovf_sticky", b_ovf, 1);
        check("b_cnt_stays", b_cnt, 4);
        check("a_no_ovf", a_ovf, 0);
        check("a_stayed_idle", a_mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
